// File: rtl/acc_pkg.sv
// Shared opcode constants and decode helpers for the acc_core_p accumulator core.
// Instruction layout: opcode in the top nibble, field F in the remaining low bits.
package acc_pkg;

    localparam int MAX_DW = 64;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_JZ  = 4'hC;
    localparam logic [3:0] OP_JN  = 4'hD;
    localparam logic [3:0] OP_RSV = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [MAX_DW-1:0] NOP_INSTR = '0;

    function automatic logic [3:0] op_of(
        input logic [MAX_DW-1:0] instr,
        input int                dw
    );
        return instr[dw-1 -: 4];
    endfunction

endpackage

// File: rtl/acc_core_p_if.sv
// Host load/inspect bus of acc_core_p: program load and data-memory access.
// master = host side, slave = core side.
interface acc_core_p_if #(
    parameter int DW       = 16,
    parameter int IM_DEPTH = 256,
    parameter int DM_DEPTH = 256
);
    localparam int IA = $clog2(IM_DEPTH);
    localparam int DA = $clog2(DM_DEPTH);

    logic          prog_we;
    logic [IA-1:0] prog_addr;
    logic [DW-1:0] prog_data;
    logic          dm_we;
    logic [DA-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;

    modport master (
        output prog_we, prog_addr, prog_data,
        output dm_we, dm_addr, dm_wdata,
        input  dm_rdata
    );

    modport slave (
        input  prog_we, prog_addr, prog_data,
        input  dm_we, dm_addr, dm_wdata,
        output dm_rdata
    );

endinterface

// File: rtl/acc_alu.sv
// Combinational next-accumulator logic for the EX stage of acc_core_p.
// Non-ALU opcodes (branches, STA, NOP, HLT, reserved) leave acc unchanged.
module acc_alu
    import acc_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] acc,
    input  logic [DW-1:0] opnd,
    input  logic [DW-5:0] f,
    output logic [DW-1:0] acc_nxt
);

    always_comb begin
        acc_nxt = acc;
        unique case (op)
            OP_LDA:  acc_nxt = opnd;
            OP_ADD:  acc_nxt = acc + opnd;
            OP_SUB:  acc_nxt = acc - opnd;
            OP_AND:  acc_nxt = acc & opnd;
            OP_OR:   acc_nxt = acc | opnd;
            OP_XOR:  acc_nxt = acc ^ opnd;
            OP_LDI:  acc_nxt = DW'(f);
            OP_SHL:  acc_nxt = acc << 1;
            OP_SHR:  acc_nxt = acc >> 1;
            default: acc_nxt = acc;
        endcase
    end

endmodule

// File: rtl/acc_core_p.sv
// acc_core_p: 3-stage (IF/OF/EX) accumulator core with internal memories.
// Define ACC_PERF_EN to add the perf_cycles / perf_retired counters.
module acc_core_p
    import acc_pkg::*;
#(
    parameter  int DW       = 16,
    parameter  int IM_DEPTH = 256,
    parameter  int DM_DEPTH = 256,
    localparam int IA       = $clog2(IM_DEPTH),
    localparam int DA       = $clog2(DM_DEPTH)
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          run,
    acc_core_p_if.slave   host,
    output logic [DW-1:0] acc,
    output logic [IA-1:0] pc,
    output logic          halted
`ifdef ACC_PERF_EN
    ,
    output logic [31:0]   perf_cycles,
    output logic [31:0]   perf_retired
`endif
);

    localparam int            FW    = DW - 4;
    localparam logic [DW-1:0] NOP_W = NOP_INSTR[DW-1:0];

    logic [DW-1:0] imem [IM_DEPTH];
    logic [DW-1:0] dmem [DM_DEPTH];

    logic [IA-1:0] pc_q, pc_d;
    logic [DW-1:0] if_ir_q, if_ir_d;
    logic [DW-1:0] of_ir_q, of_ir_d;
    logic [DW-1:0] of_opnd_q, of_opnd_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          halted_q, halted_d;

    logic          adv;
    logic [IA-1:0] pc_inc;
    logic [3:0]    ex_op;
    logic [FW-1:0] if_f, ex_f;
    logic [DA-1:0] if_da, ex_da;
    logic [IA-1:0] ex_ia;
    logic          ex_take, ex_hlt, ex_sta;
    logic          host_dm_ok;
    logic [DW-1:0] alu_acc;

    assign adv    = run && !halted_q;
    assign pc_inc = (pc_q == IA'(IM_DEPTH - 1)) ? '0 : pc_q + 1'b1;

    assign if_f  = if_ir_q[FW-1:0];
    assign ex_f  = of_ir_q[FW-1:0];
    assign if_da = DA'(if_f);
    assign ex_da = DA'(ex_f);
    assign ex_ia = IA'(ex_f);
    assign ex_op = op_of(MAX_DW'(of_ir_q), DW);

    // Branch conditions look at acc as it stands while the branch is in EX
    assign ex_take = adv && ((ex_op == OP_JMP)
                          || (ex_op == OP_JZ && acc_q == '0)
                          || (ex_op == OP_JN && acc_q[DW-1]));
    assign ex_hlt  = adv && (ex_op == OP_HLT);
    assign ex_sta  = adv && (ex_op == OP_STA) && !rst;

    assign host_dm_ok = host.dm_we && (!run || halted_q);

    acc_alu #(.DW(DW)) u_alu (
        .op      (ex_op),
        .acc     (acc_q),
        .opnd    (of_opnd_q),
        .f       (ex_f),
        .acc_nxt (alu_acc)
    );

    always_comb begin
        pc_d      = pc_q;
        if_ir_d   = if_ir_q;
        of_ir_d   = of_ir_q;
        of_opnd_d = of_opnd_q;
        acc_d     = acc_q;
        halted_d  = halted_q;
        if (adv) begin
            pc_d    = pc_inc;
            if_ir_d = imem[pc_q];
            of_ir_d = if_ir_q;
            // STA in EX writes this same edge, so bypass the stale word
            if (ex_op == OP_STA && ex_da == if_da)
                of_opnd_d = acc_q;
            else
                of_opnd_d = dmem[if_da];
            acc_d = alu_acc;
            if (ex_take) begin
                pc_d    = ex_ia;
                if_ir_d = NOP_W;
                of_ir_d = NOP_W;
            end
            if (ex_hlt) begin
                pc_d     = pc_q;
                if_ir_d  = NOP_W;
                of_ir_d  = NOP_W;
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            pc_q      <= '0;
            if_ir_q   <= NOP_W;
            of_ir_q   <= NOP_W;
            of_opnd_q <= '0;
            acc_q     <= '0;
            halted_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            if_ir_q   <= if_ir_d;
            of_ir_q   <= of_ir_d;
            of_opnd_q <= of_opnd_d;
            acc_q     <= acc_d;
            halted_q  <= halted_d;
        end
    end

    // Core and host dm writes are mutually exclusive via run/halted
    always_ff @(posedge clk1) begin
        if (host.prog_we)
            imem[host.prog_addr] <= host.prog_data;
        if (ex_sta)
            dmem[ex_da] <= acc_q;
        else if (host_dm_ok)
            dmem[host.dm_addr] <= host.dm_wdata;
    end

    assign host.dm_rdata = dmem[host.dm_addr];

    assign acc    = acc_q;
    assign pc     = pc_q;
    assign halted = halted_q;

`ifdef ACC_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_retired_q, perf_retired_d;

    always_comb begin
        perf_cycles_d  = perf_cycles_q;
        perf_retired_d = perf_retired_q;
        if (adv) begin
            perf_cycles_d = perf_cycles_q + 32'd1;
            if (ex_op != OP_NOP)
                perf_retired_d = perf_retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            perf_cycles_q  <= '0;
            perf_retired_q <= '0;
        end else begin
            perf_cycles_q  <= perf_cycles_d;
            perf_retired_q <= perf_retired_d;
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_retired = perf_retired_q;
`endif

endmodule

// File: tb/tb_acc_core_p.sv
// Directed scoreboard bench for acc_core_p: programs, forwarding, branches,
// stall, mid-run reset, and PC wrap on a 16-word instruction memory.
module tb_acc_core_p;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic        rst, run, rst2, run2;
    logic [15:0] acc, acc2;
    logic [7:0]  pc;
    logic [3:0]  pc2;
    logic        halted, halted2;
`ifdef ACC_PERF_EN
    logic [31:0] pcyc1, pret1, pcyc2, pret2;
`endif

    acc_core_p_if #(.DW(16), .IM_DEPTH(256), .DM_DEPTH(256)) h ();
    acc_core_p_if #(.DW(16), .IM_DEPTH(16),  .DM_DEPTH(256)) h2 ();

    acc_core_p #(.DW(16), .IM_DEPTH(256), .DM_DEPTH(256)) dut (
        .clk1   (clk1),
        .rst    (rst),
        .run    (run),
        .host   (h),
        .acc    (acc),
        .pc     (pc),
        .halted (halted)
`ifdef ACC_PERF_EN
        ,
        .perf_cycles  (pcyc1),
        .perf_retired (pret1)
`endif
    );

    acc_core_p #(.DW(16), .IM_DEPTH(16), .DM_DEPTH(256)) dut2 (
        .clk1   (clk1),
        .rst    (rst2),
        .run    (run2),
        .host   (h2),
        .acc    (acc2),
        .pc     (pc2),
        .halted (halted2)
`ifdef ACC_PERF_EN
        ,
        .perf_cycles  (pcyc2),
        .perf_retired (pret2)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] prog [$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_empty: got %0h want none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                n_err++;
                $error("FAIL %s: got %0h want %0h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk1);
    endtask

    task automatic pload(input logic [7:0] a, input logic [15:0] d);
        h.prog_we   = 1'b1;
        h.prog_addr = a;
        h.prog_data = d;
        tick(1);
        h.prog_we   = 1'b0;
    endtask

    task automatic pload2(input logic [3:0] a, input logic [15:0] d);
        h2.prog_we   = 1'b1;
        h2.prog_addr = a;
        h2.prog_data = d;
        tick(1);
        h2.prog_we   = 1'b0;
    endtask

    task automatic dmw(input logic [7:0] a, input logic [15:0] d);
        h.dm_we    = 1'b1;
        h.dm_addr  = a;
        h.dm_wdata = d;
        tick(1);
        h.dm_we    = 1'b0;
    endtask

    task automatic chk_dm(input logic [7:0] a);
        h.dm_addr = a;
        #1;
        chk(32'(h.dm_rdata));
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++)
            pload(8'(i), (i < prog.size()) ? prog[i] : 16'h0000);
    endtask

    task automatic restart();
        run = 1'b0;
        rst = 1'b1;
        tick(1);
    endtask

    task automatic wait_halt(input int max);
        int i;
        i = 0;
        while (!halted && i < max) begin
            tick(1);
            i++;
        end
    endtask

    task automatic wait_halt2(input int max);
        int i;
        i = 0;
        while (!halted2 && i < max) begin
            tick(1);
            i++;
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; rst2 = 1'b1; run2 = 1'b0;
        h.prog_we = 1'b0; h.prog_addr = '0; h.prog_data = '0;
        h.dm_we = 1'b0; h.dm_addr = '0; h.dm_wdata = '0;
        h2.prog_we = 1'b0; h2.prog_addr = '0; h2.prog_data = '0;
        h2.dm_we = 1'b0; h2.dm_addr = '0; h2.dm_wdata = '0;
        tick(2);

        push("rst_acc", 0); push("rst_pc", 0); push("rst_halt", 0);
        chk(32'(acc)); chk(32'(pc)); chk(32'(halted));

        // basic program
        prog = '{16'h8005, 16'h3001, 16'h2003, 16'hF000};
        load_prog();
        dmw(8'd1, 16'd2);
        dmw(8'd3, 16'd0);
        rst = 1'b0;
        tick(1);
        push("t1_halt", 1); push("t1_acc", 7);
        push("t1_pc", 5); push("t1_dm3", 7); push("t1_pc_hold", 5);
        run = 1'b1;
        tick(6);
        chk(32'(halted)); chk(32'(acc)); chk(32'(pc)); chk_dm(8'd3);
        tick(3);
        chk(32'(pc));
`ifdef ACC_PERF_EN
        push("t1_cyc", 6); push("t1_ret", 4);
        chk(pcyc1); chk(pret1);
`endif

        // store-to-load forwarding
        restart();
        prog = '{16'h8009, 16'h2004, 16'h1004, 16'h3004, 16'hF000};
        load_prog();
        dmw(8'd4, 16'd0);
        rst = 1'b0;
        push("t2_halt", 1); push("t2_acc", 18); push("t2_dm4", 9);
        run = 1'b1;
        wait_halt(20);
        chk(32'(halted)); chk(32'(acc)); chk_dm(8'd4);

        // taken JZ flushes two LDIs
        restart();
        prog = '{16'h8000, 16'hC004, 16'h8009, 16'h8009, 16'hF000};
        load_prog();
        rst = 1'b0;
        push("t3_halt", 1); push("t3_acc", 0);
        run = 1'b1;
        wait_halt(20);
        chk(32'(halted)); chk(32'(acc));
`ifdef ACC_PERF_EN
        push("t3_ret", 3);
        chk(pret1);
`endif

        // untaken JZ/JN, SHL, JMP flush
        restart();
        prog = '{16'h8007, 16'hC005, 16'h9000, 16'hB005,
                 16'h8001, 16'hD007, 16'hF000};
        load_prog();
        rst = 1'b0;
        push("t3b_halt", 1); push("t3b_acc", 16'h000E);
        run = 1'b1;
        wait_halt(20);
        chk(32'(halted)); chk(32'(acc));

        // logic ops, SUB wrap, taken JN
        restart();
        prog = '{16'h80FF, 16'h500A, 16'h600B, 16'h700A, 16'h400B,
                 16'h400B, 16'hD008, 16'h8000, 16'hF000};
        load_prog();
        dmw(8'd10, 16'h00F0);
        dmw(8'd11, 16'h0F0F);
        rst = 1'b0;
        push("t3c_halt", 1); push("t3c_acc", 16'hF0F1);
        run = 1'b1;
        wait_halt(30);
        chk(32'(halted)); chk(32'(acc));

        // stall with run=0, host dm write gating
        restart();
        prog = '{16'h8005, 16'h3001, 16'h2003, 16'hF000};
        load_prog();
        dmw(8'd1, 16'd2);
        dmw(8'd3, 16'd0);
        dmw(8'd20, 16'd0);
        dmw(8'd21, 16'd0);
        rst = 1'b0;
        run = 1'b1;
        tick(3);
        push("s_acc", 5); push("s_pc", 3); push("s_dm3", 0); push("s_dm20", 16'h55);
        run = 1'b0;
        h.dm_we = 1'b1; h.dm_addr = 8'd20; h.dm_wdata = 16'h0055;
        tick(1);
        h.dm_we = 1'b0;
        tick(4);
        chk(32'(acc)); chk(32'(pc)); chk_dm(8'd3); chk_dm(8'd20);
        push("s_halt", 1); push("s_acc_end", 7); push("s_dm3_end", 7);
        push("s_dm21", 0); push("s_dm20_end", 16'h55);
        run = 1'b1;
        h.dm_we = 1'b1; h.dm_addr = 8'd21; h.dm_wdata = 16'h00AA;
        tick(1);
        h.dm_we = 1'b0;
        wait_halt(20);
        chk(32'(halted)); chk(32'(acc)); chk_dm(8'd3);
        chk_dm(8'd21); chk_dm(8'd20);

        // reset while STA 7 sits in EX
        restart();
        prog = '{16'h8003, 16'h2007, 16'hF000};
        load_prog();
        dmw(8'd7, 16'h0011);
        rst = 1'b0;
        run = 1'b1;
        tick(3);
        push("r_dm7", 16'h11); push("r_acc", 0); push("r_pc", 0); push("r_halt", 0);
        rst = 1'b1;
        tick(1);
        chk_dm(8'd7); chk(32'(acc)); chk(32'(pc)); chk(32'(halted));
        rst = 1'b0;
        push("r2_halt", 1); push("r2_acc", 3); push("r2_dm7", 3);
        wait_halt(20);
        chk(32'(halted)); chk(32'(acc)); chk_dm(8'd7);

        // PC wrap on 16-word instruction memory
        for (int i = 0; i < 15; i++)
            pload2(4'(i), 16'h0000);
        pload2(4'd15, 16'h8005);
        rst2 = 1'b0;
        run2 = 1'b1;
        tick(2);
        pload2(4'd0, 16'hF000);
        tick(13);
        push("w_pc_wrap", 0);
        chk(32'(pc2));
        push("w_halt", 1); push("w_acc", 5); push("w_pc_end", 2);
        wait_halt2(20);
        chk(32'(halted2)); chk(32'(acc2)); chk(32'(pc2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
